csa4_divider: RTL and testbench



---
 rtl/csa4_divider_pkg.sv | 7 +
 rtl/csa4_divider_if.sv | 17 +
 rtl/csa4_divider_sub5_cs.sv | 18 +
 rtl/csa4_divider.sv | 89 ++++++++
 tb/tb_csa4_divider.sv | 128 ++++++++++++
 5 files changed

// File: rtl/csa4_divider_pkg.sv
// csa4_div_pkg: shared widths, state encoding and step count for the 4-bit restoring divider
package csa4_div_pkg;
    localparam int WIDTH  = 4;
    localparam int RWIDTH = 5;
    localparam int STEPS  = 4;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/csa4_divider_if.sv
// csa4_divider_if: start/done handshake and operand/result bus between controller and divider
interface csa4_divider_if
    import csa4_div_pkg::*;
();
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    modport master (output start, dividend, divisor,
                    input  busy, done, quotient, remainder, div_by_zero);
    modport slave  (input  start, dividend, divisor,
                    output busy, done, quotient, remainder, div_by_zero);
endinterface

// File: rtl/csa4_divider_sub5_cs.sv
// sub5_cs: 5-bit carry-select subtractor a + ~b + 1; no_borrow is the carry out
module sub5_cs
    import csa4_div_pkg::*;
(
    input  logic [RWIDTH-1:0] i_a,
    input  logic [RWIDTH-1:0] i_b,
    output logic [RWIDTH-1:0] o_diff,
    output logic              o_no_borrow
);
    logic [2:0] w_lo;
    logic [3:0] w_hi0;
    logic [3:0] w_hi1;
    assign w_lo  = {1'b0, i_a[1:0]} + {1'b0, ~i_b[1:0]} + 3'd1;
    assign w_hi0 = {1'b0, i_a[4:2]} + {1'b0, ~i_b[4:2]};
    assign w_hi1 = {1'b0, i_a[4:2]} + {1'b0, ~i_b[4:2]} + 4'd1;
    assign o_diff      = {w_lo[2] ? w_hi1[2:0] : w_hi0[2:0], w_lo[1:0]};
    assign o_no_borrow = w_lo[2] ? w_hi1[3] : w_hi0[3];
endmodule

// File: rtl/csa4_divider.sv
// csa4_divider: sequential 4-bit unsigned restoring divider, one subtract-and-shift per clock
// CSA_DIV_ZERO_BYPASS_EN: a zero divisor skips iteration and completes one cycle after accept
module csa4_divider
    import csa4_div_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    csa4_divider_if.slave bus
);
    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_cnt;
    logic [WIDTH-1:0]  r_q;
    logic [WIDTH-1:0]  r_d;
    logic [RWIDTH-1:0] r_r;
    logic [WIDTH-1:0]  r_quot;
    logic [WIDTH-1:0]  r_rem;
    logic              r_dbz;
    logic [RWIDTH-1:0] w_r_sh;
    logic [RWIDTH-1:0] w_diff;
    logic              w_nb;
    logic              w_take;
    logic [RWIDTH-1:0] w_r_step;
    logic [WIDTH-1:0]  w_q_step;
    logic              w_accept;
    logic              w_bypass;
    assign w_r_sh = {r_r[3:0], r_q[3]};
    sub5_cs u_sub (
        .i_a         (w_r_sh),
        .i_b         ({1'b0, r_d}),
        .o_diff      (w_diff),
        .o_no_borrow (w_nb)
    );
    // r_r[4] is always 0 between steps; if it were set the trial would trivially fit
    assign w_take   = w_nb | r_r[4];
    assign w_r_step = w_take ? w_diff : w_r_sh;
    assign w_q_step = {r_q[2:0], w_take};
    assign w_accept = (r_state != RUN) && bus.start;
`ifdef CSA_DIV_ZERO_BYPASS_EN
    assign w_bypass = w_accept && (bus.divisor == '0);
`else
    assign w_bypass = 1'b0;
`endif
    always_comb begin
        w_state_nxt = IDLE;
        w_state_nxt = w_accept ? (w_bypass ? DONE : RUN)
                    : (r_state == RUN) ? ((r_cnt == 2'd0) ? DONE : RUN)
                    : IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_q     <= '0;
            r_d     <= '0;
            r_r     <= '0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_dbz   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_q   <= bus.dividend;
                r_d   <= bus.divisor;
                r_r   <= '0;
                r_cnt <= 2'(STEPS - 1);
            end else if (r_state == RUN) begin
                r_q   <= w_q_step;
                r_r   <= w_r_step;
                r_cnt <= r_cnt - 2'd1;
                if (r_cnt == 2'd0) begin
                    r_quot <= w_q_step;
                    r_rem  <= w_r_step[3:0];
                    r_dbz  <= (r_d == '0);
                end
            end
            if (w_bypass) begin
                r_quot <= '1;
                r_rem  <= bus.dividend;
                r_dbz  <= 1'b1;
            end
        end
    end
    assign bus.busy        = (r_state == RUN);
    assign bus.done        = (r_state == DONE);
    assign bus.quotient    = r_quot;
    assign bus.remainder   = r_rem;
    assign bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_csa4_divider.sv
// tb_csa4_divider: directed vectors with hand-computed quotient/remainder and latency checks
module tb_csa4_divider;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;
    int   lat;
    csa4_divider_if bus();
    csa4_divider dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
`ifdef CSA_DIV_ZERO_BYPASS_EN
    localparam int ZLAT = 0;
`else
    localparam int ZLAT = 4;
`endif
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic wait_done(output int n);
        n = 0;
        while (!bus.done && n < 10) begin
            tick();
            n++;
        end
    endtask
    task automatic run_div(input string tag, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] eq, input logic [3:0] er, input logic ez,
                           input int elat);
        int n;
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        tick();
        bus.start = 1'b0;
        chk({tag, " busy"}, 32'(bus.busy), 32'(elat != 0));
        wait_done(n);
        chk({tag, " lat"}, n, elat);
        chk({tag, " q"}, 32'(bus.quotient), 32'(eq));
        chk({tag, " r"}, 32'(bus.remainder), 32'(er));
        chk({tag, " dbz"}, 32'(bus.div_by_zero), 32'(ez));
        tick();
        chk({tag, " done pulse"}, 32'(bus.done), 0);
    endtask
    initial begin
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst busy", 32'(bus.busy), 0);
        chk("rst done", 32'(bus.done), 0);
        chk("rst q", 32'(bus.quotient), 0);
        chk("rst r", 32'(bus.remainder), 0);
        chk("rst dbz", 32'(bus.div_by_zero), 0);
        run_div("13/3", 4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 4);
        run_div("15/1", 4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 4);
        run_div("2/7", 4'd2, 4'd7, 4'd0, 4'd2, 1'b0, 4);
        run_div("0/5", 4'd0, 4'd5, 4'd0, 4'd0, 1'b0, 4);
        run_div("15/15", 4'd15, 4'd15, 4'd1, 4'd0, 1'b0, 4);
        run_div("9/0", 4'd9, 4'd0, 4'hF, 4'd9, 1'b1, ZLAT);
        // start during RUN must be ignored
        bus.start = 1'b1; bus.dividend = 4'd12; bus.divisor = 4'd5;
        tick();
        bus.start = 1'b0;
        tick();
        bus.start = 1'b1; bus.dividend = 4'd7; bus.divisor = 4'd2;
        tick();
        bus.start = 1'b0;
        wait_done(lat);
        chk("ign lat", lat, 2);
        chk("ign q", 32'(bus.quotient), 2);
        chk("ign r", 32'(bus.remainder), 2);
        tick();
        chk("ign idle busy", 32'(bus.busy), 0);
        wait_done(lat);
        chk("ign no 2nd done", lat, 10);
        // reset mid-run clears everything; a start alongside reset is dropped
        bus.start = 1'b1; bus.dividend = 4'd11; bus.divisor = 4'd3;
        tick();
        bus.start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rrun busy", 32'(bus.busy), 0);
        chk("rrun done", 32'(bus.done), 0);
        chk("rrun q", 32'(bus.quotient), 0);
        chk("rrun r", 32'(bus.remainder), 0);
        chk("rrun dbz", 32'(bus.div_by_zero), 0);
        wait_done(lat);
        chk("rrun no done", lat, 10);
        rst = 1'b1; bus.start = 1'b1;
        tick();
        rst = 1'b0; bus.start = 1'b0;
        chk("rst+start busy", 32'(bus.busy), 0);
        run_div("11/3", 4'd11, 4'd3, 4'd3, 4'd2, 1'b0, 4);
        // back-to-back with start held through DONE
        bus.start = 1'b1; bus.dividend = 4'd14; bus.divisor = 4'd4;
        tick();
        bus.dividend = 4'd6; bus.divisor = 4'd6;
        wait_done(lat);
        chk("b2b1 lat", lat, 4);
        chk("b2b1 q", 32'(bus.quotient), 3);
        chk("b2b1 r", 32'(bus.remainder), 2);
        tick();
        bus.start = 1'b0;
        chk("b2b hold busy", 32'(bus.busy), 1);
        chk("b2b hold q", 32'(bus.quotient), 3);
        chk("b2b hold r", 32'(bus.remainder), 2);
        wait_done(lat);
        chk("b2b2 lat", lat + 1, 5);
        chk("b2b2 q", 32'(bus.quotient), 1);
        chk("b2b2 r", 32'(bus.remainder), 0);
        tick();
        chk("b2b2 idle", 32'(bus.done), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
